mult_div_unit: RTL

- Multicycle signed multiply/divide unit beside the main datapath, started by the control FSM's MultCtrl/DivCtrl pulses.
- Operands come from the A and B registers; results go to the HI/LO registers, which MemToReg selects when mfhi/mflo are executed.
- Multiply is radix-2 Booth and divide is restoring. Each iterates one bit per clock.
- The unit tells the control FSM when it is busy and when a result has landed.

---
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit.
// Radix-2 Booth multiply and restoring divide, one bit per clock.
// The HI/LO result registers are written only when an operation completes.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Booth datapath: WIDTH+1-bit upper half keeps the (-2^(W-1))^2 product exact
  logic [WIDTH:0]     mcand;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               q_m1;

  // Restoring divide datapath on magnitudes
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     dvs;
  logic               sign_a;
  logic               sign_b;

  // Combinational next-step values
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     mult_hi_nxt;
  logic [WIDTH-1:0]   mult_lo_nxt;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [WIDTH:0]     rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;
  logic [WIDTH:0]     abs_a;
  logic [WIDTH:0]     abs_b;

  assign busy = (state != IDLE);

  // Operand magnitudes in WIDTH+1 bits so the most negative value is representable
  always_comb begin
    abs_a = {op_a[WIDTH-1], op_a};
    abs_b = {op_b[WIDTH-1], op_b};
    if (op_a[WIDTH-1]) abs_a = (WIDTH+1)'(0) - {op_a[WIDTH-1], op_a};
    if (op_b[WIDTH-1]) abs_b = (WIDTH+1)'(0) - {op_b[WIDTH-1], op_b};
  end

  // One Booth step: add/sub on {q0,q-1}, then arithmetic shift right
  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + mcand;
      2'b10:   booth_sum = acc_hi - mcand;
      default: booth_sum = acc_hi;
    endcase
    mult_hi_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mult_lo_nxt = {booth_sum[0], acc_lo[WIDTH-1:1]};
    product     = {mult_hi_nxt[WIDTH-1:0], mult_lo_nxt};
  end

  // One restoring divide step plus final sign fix-up of quotient and remainder
  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    quo_sh  = {quo[WIDTH-2:0], 1'b0};
    rem_nxt = rem_sh;
    quo_nxt = quo_sh;
    if (rem_sh >= dvs) begin
      rem_nxt = rem_sh - dvs;
      quo_nxt = quo_sh | WIDTH'(1);
    end
    quo_fin = (sign_a ^ sign_b) ? (WIDTH'(0) - quo_nxt) : quo_nxt;
    rem_fin = sign_a ? (WIDTH'(0) - rem_nxt[WIDTH-1:0]) : rem_nxt[WIDTH-1:0];
  end

  // Control FSM and all datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      q_m1     <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          // multiply has priority when both starts arrive together
          if (mult_start) begin
            mcand  <= {op_a[WIDTH-1], op_a};
            acc_hi <= '0;
            acc_lo <= op_b;
            q_m1   <= 1'b0;
            cnt    <= CNT_W'(WIDTH);
            state  <= MULT;
          end else if (div_start) begin
            if (op_b == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= FINISH;
            end else begin
              quo    <= abs_a[WIDTH-1:0];
              dvs    <= abs_b;
              rem    <= '0;
              sign_a <= op_a[WIDTH-1];
              sign_b <= op_b[WIDTH-1];
              cnt    <= CNT_W'(WIDTH);
              state  <= DIV;
            end
          end
        end
        MULT: begin
          acc_hi <= mult_hi_nxt;
          acc_lo <= mult_lo_nxt;
          q_m1   <= acc_lo[0];
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi    <= product[2*WIDTH-1:WIDTH];
            lo    <= product[WIDTH-1:0];
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi    <= rem_fin;
            lo    <= quo_fin;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
